rep3_serial_tx: RTL and testbench
=================================

Name: rep3_serial_tx

Overview:
- Serial transmitter for a triple-repetition code. Every frame symbol (start, data bits, stop) is sent as three identical consecutive chips.
- The far end recovers each symbol with a 3-input majority vote, so any single corrupted chip per symbol is corrected.
- Sits between a parallel data source (switches or a test FSM) and a single output pin or loopback wire feeding the voting receiver.

Parameters:
- DATA_W, 8, payload bits per frame, sent LSB first.
- CHIP_DIV, 4, clock cycles per chip (integer ≥1).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  DATA_W  payload, sampled on handshake.
- tx_valid  input  1  source has a payload.
- tx_ready  output  1  block can accept a payload.
- ser_out  output  1  serial line; idle high.
- busy  output  1  frame in progress.
- chip_idx  output  2  current repetition index 0..2 (debug).
- err_inj  input  1  error-injection request; present only with RTL_ERR_INJECT_EN.

Behaviour:
- Reset: one clock, synchronous, active-high. All outputs are registered.
  - Reset values: ser_out=1, tx_ready=1, busy=0, chip_idx=0.
  - Counters and the shift register clear; state becomes IDLE.
- State machine: IDLE → START → DATA → STOP → IDLE.
- Handshake:
  - A transfer occurs on the rising edge where tx_valid & tx_ready = 1.
  - tx_data is latched into the shift register at that edge.
  - tx_ready is 1 only in IDLE. It goes 0 on the edge after acceptance and stays 0 until the frame ends.
  - tx_valid while tx_ready=0 is ignored. tx_data may change freely after acceptance.
- Chip timing:
  - Every chip holds ser_out for exactly CHIP_DIV cycles.
  - A symbol spans 3 chips; chip_idx counts 0,1,2 within each symbol.
- START: 3 chips of 0. ser_out falls on the cycle immediately after acceptance (one-cycle latency).
- DATA:
  - DATA_W symbols, LSB first. Each bit is repeated on 3 chips.
  - The shift register shifts right after the third chip of each bit.
- STOP: 3 chips of 1.
- Frame length: (DATA_W+2)·3·CHIP_DIV cycles. Defaults give 120.
- Frame end:
  - After the last STOP chip, the block returns to IDLE with tx_ready=1 and busy=0.
  - If tx_valid is held high, the next frame is accepted in that IDLE cycle. Back-to-back frames therefore have exactly one idle-high cycle between them.
- busy: 1 from the cycle after acceptance through the final STOP cycle.
- rst mid-frame: the frame is aborted and ser_out=1 on the next edge. No partial resume.
- Counter widths: the chip-divider counter is sized as ceil(log2(CHIP_DIV)). CHIP_DIV=1 must work (chip changes every cycle).

Optional Feature:
- Macro: RTL_ERR_INJECT_EN.
- Defined:
  - The err_inj port exists and is sampled at acceptance.
  - If err_inj=1, chip_idx 1 of data bit 0 is inverted. Exactly one chip per frame is corrupted.
  - A working majority receiver must still decode the correct byte.
- Undefined:
  - The port is absent and all chips equal their symbol value.
  - Behaviour is identical to defined-with-err_inj=0.

Decomposition:
- Package rep3_pkg:
  - State enum {IDLE, START, DATA, STOP}.
  - Constant REP=3.
  - Constants IDLE_LVL=1, START_LVL=0, STOP_LVL=1.
- Sub-module chip_timer:
  - Counts 0..CHIP_DIV-1 and emits a one-cycle chip_tick on terminal count.
  - Clears on rst or on a start pulse.
- Top FSM: owns chip_idx, bit counter and shift register.

Test Plan:
1. Reset then idle, DATA_W=8, CHIP_DIV=4: hold rst 2 cycles → ser_out=1, tx_ready=1, busy=0; values hold for 50 idle cycles.
2. Single frame, tx_data=0xA5 pulsed valid 1 cycle:
   - ser_out low for cycles 1–12 after acceptance.
   - Chip stream thereafter is 111 000 111 000 000 111 000 111, then 111 stop.
   - tx_ready returns to 1 at cycle 121.
3. Back-to-back frames, valid held high with 0x00 then 0xFF:
   - Exactly one idle-high cycle between frames.
   - Second frame shows 24 data chips of 1.
4. Ignored input: tx_valid pulsed mid-frame with 0x3C → no acceptance, tx_ready stays 0, current frame bits unchanged.
5. Reset mid-frame: assert rst at cycle 50 of a frame → ser_out=1 and tx_ready=1 next edge; a new 0x81 frame then transmits correctly.
6. Error injection (RTL_ERR_INJECT_EN defined), 0x01 with err_inj=1:
   - Bit-0 chips read 1,0,1.
   - Loopback through the majority receiver yields 0x01.
   - Same test with the macro undefined shows chips 1,1,1.

Source files
------------

// File: rtl/rep3_serial_tx_pkg.sv
// Shared types and constants for the triple-repetition serial transmitter.
//   state_t   : frame FSM states
//   REP       : chips per symbol
//   *_LVL     : line levels for idle, start and stop symbols
//   cnt_w()   : counter width helper, never less than one bit
package rep3_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int   REP       = 3;
  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // ceil(log2(v)) is zero for v==1; a zero-width counter is not legal,
  // so keep at least one bit.
  function automatic int cnt_w(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/rep3_serial_tx_if.sv
// Payload handshake bundle for rep3_serial_tx.
//   tx_data  : payload, sampled on tx_valid & tx_ready
//   tx_valid : source has a payload
//   tx_ready : transmitter can accept a payload
// master = data source, slave = transmitter.
interface rep3_serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/rep3_serial_tx_chip_timer.sv
// Chip-period divider. Counts 0..CHIP_DIV-1 and raises chip_tick for the
// single cycle the count sits at its terminal value.
//   clk, rst  : clock, synchronous active-high reset
//   start     : restart the count at 0 (aligns chips to frame acceptance)
//   chip_tick : last cycle of the current chip
// With CHIP_DIV=1 the counter stays at 0 and chip_tick is always high.
module chip_timer
  import rep3_pkg::*;
#(
  parameter int CHIP_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic chip_tick
);
  localparam int CW = cnt_w(CHIP_DIV);
  localparam logic [CW-1:0] TERM = CW'(CHIP_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || start)     cnt <= '0;
    else if (cnt == TERM) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign chip_tick = (cnt == TERM);
endmodule

// File: rtl/rep3_serial_tx.sv
// Triple-repetition serial transmitter. Each frame symbol (start, DATA_W
// payload bits LSB first, stop) goes out as three identical chips of
// CHIP_DIV cycles each, so a majority-vote receiver corrects any single
// bad chip per symbol. Frame length is (DATA_W+2)*3*CHIP_DIV cycles.
//   clk, rst : clock, synchronous active-high reset
//   tx       : payload handshake (slave side)
//   err_inj  : corrupt chip 1 of data bit 0 in this frame; sampled at
//              acceptance (present only with RTL_ERR_INJECT_EN)
//   ser_out  : serial line, idle high
//   busy     : frame in progress
//   chip_idx : repetition index within the current symbol (debug)
// Optional feature macro: RTL_ERR_INJECT_EN.
module rep3_serial_tx
  import rep3_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CHIP_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
`ifdef RTL_ERR_INJECT_EN
  input  logic               err_inj,
`endif
  rep3_serial_tx_if.slave    tx,
  output logic               ser_out,
  output logic               busy,
  output logic [1:0]         chip_idx
);
  localparam int BW = cnt_w(DATA_W);
  localparam logic [1:0]    LAST_CHIP = 2'(REP - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] sh_nxt;
  logic [BW-1:0]     bit_cnt;
  logic              chip_tick;
  logic              accept;
  logic              last_chip;
  logic              corrupt_nxt;

  assign accept    = tx.tx_valid & tx.tx_ready;
  assign last_chip = (chip_idx == LAST_CHIP);
  assign sh_nxt    = sh >> 1;

`ifdef RTL_ERR_INJECT_EN
  logic inj_q;
  // Invert only when moving from chip 0 to chip 1 of bit 0; the move to
  // chip 2 restores the true value, so one chip per frame is wrong.
  assign corrupt_nxt = inj_q && (bit_cnt == '0) && (chip_idx == 2'd0);

  always_ff @(posedge clk) begin
    if (rst)         inj_q <= 1'b0;
    else if (accept) inj_q <= err_inj;
  end
`else
  assign corrupt_nxt = 1'b0;
`endif

  // Restart chip timing on acceptance so the first start chip is a full
  // CHIP_DIV cycles long regardless of where the idle count was.
  chip_timer #(.CHIP_DIV(CHIP_DIV)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .start     (accept),
    .chip_tick (chip_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ser_out     <= IDLE_LVL;
      tx.tx_ready <= 1'b1;
      busy        <= 1'b0;
      chip_idx    <= 2'd0;
      sh          <= '0;
      bit_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= START;
            sh          <= tx.tx_data;
            ser_out     <= START_LVL;
            tx.tx_ready <= 1'b0;
            busy        <= 1'b1;
            chip_idx    <= 2'd0;
            bit_cnt     <= '0;
          end
        end
        START: begin
          if (chip_tick) begin
            if (last_chip) begin
              state    <= DATA;
              chip_idx <= 2'd0;
              ser_out  <= sh[0];
            end else begin
              chip_idx <= chip_idx + 2'd1;
            end
          end
        end
        DATA: begin
          if (chip_tick) begin
            if (last_chip) begin
              chip_idx <= 2'd0;
              sh       <= sh_nxt;
              if (bit_cnt == LAST_BIT) begin
                state   <= STOP;
                ser_out <= STOP_LVL;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                ser_out <= sh_nxt[0];
              end
            end else begin
              chip_idx <= chip_idx + 2'd1;
              ser_out  <= sh[0] ^ corrupt_nxt;
            end
          end
        end
        STOP: begin
          if (chip_tick) begin
            if (last_chip) begin
              state       <= IDLE;
              chip_idx    <= 2'd0;
              ser_out     <= IDLE_LVL;
              tx.tx_ready <= 1'b1;
              busy        <= 1'b0;
            end else begin
              chip_idx <= chip_idx + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rep3_serial_tx.sv
module tb_rep3_serial_tx;
  localparam int DW    = 8;
  localparam int CD    = 4;
  localparam int FRAME = (DW + 2) * 3 * CD;

  logic       clk = 1'b0;
  logic       rst;
  logic       err_inj;
  logic       ser_out;
  logic       busy;
  logic [1:0] chip_idx;

  int checks = 0;
  int errors = 0;

  logic exp_q[$];
  logic cap [0:FRAME-1];
  logic [4:0] got_v, exp_v;

  rep3_serial_tx_if #(.DATA_W(DW)) tx_if ();

  rep3_serial_tx #(.DATA_W(DW), .CHIP_DIV(CD)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef RTL_ERR_INJECT_EN
    .err_inj  (err_inj),
`endif
    .tx       (tx_if),
    .ser_out  (ser_out),
    .busy     (busy),
    .chip_idx (chip_idx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected ser_out per cycle for one frame, cycles 1..FRAME after accept.
  task automatic push_frame(input logic [DW-1:0] d, input logic inj);
    for (int s = 0; s < DW + 2; s++) begin
      logic v;
      v = (s == 0) ? 1'b0 : (s == DW + 1) ? 1'b1 : d[s-1];
      for (int c = 0; c < 3; c++)
        for (int t = 0; t < CD; t++)
          exp_q.push_back(v ^ (inj && s == 1 && c == 1));
    end
  endtask

  function automatic logic [4:0] frame_exp(input int k, input logic b);
    return {b, 1'b1, 1'b0, 2'(((k - 1) / CD) % 3)};
  endfunction

  // Majority vote on mid-chip samples of the captured frame.
  function automatic logic [DW-1:0] decode();
    logic [DW-1:0] r;
    for (int b = 0; b < DW; b++) begin
      int votes;
      votes = 0;
      for (int c = 0; c < 3; c++)
        votes += int'(cap[(b + 1) * 3 * CD + c * CD + CD / 2]);
      r[b] = (votes >= 2);
    end
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      got_v = {ser_out, busy, tx_if.tx_ready, chip_idx};
      checks++;
      if (got_v !== 5'b1_0_1_00) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%b want=10100", k, got_v);
      end
      step();
    end
  endtask

  task automatic test_single();
    tx_if.tx_data = 8'hA5; tx_if.tx_valid = 1'b1;
    step();
    tx_if.tx_valid = 1'b0; tx_if.tx_data = 8'h00;
    push_frame(8'hA5, 1'b0);
    for (int k = 1; k <= FRAME; k++) begin
      exp_v = frame_exp(k, exp_q.pop_front());
      got_v = {ser_out, busy, tx_if.tx_ready, chip_idx};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL single cyc=%0d got=%b want=%b", k, got_v, exp_v);
      end
      cap[k-1] = ser_out;
      step();
    end
    got_v = {ser_out, busy, tx_if.tx_ready, chip_idx};
    checks++;
    if (got_v !== 5'b1_0_1_00) begin
      errors++;
      $display("FAIL single_end got=%b want=10100", got_v);
    end
    checks++;
    if (decode() !== 8'hA5) begin
      errors++;
      $display("FAIL single_decode got=%h want=a5", decode());
    end
  endtask

  task automatic test_back_to_back();
    tx_if.tx_data = 8'h00; tx_if.tx_valid = 1'b1;
    step();
    tx_if.tx_data = 8'hFF;
    push_frame(8'h00, 1'b0);
    for (int k = 1; k <= FRAME; k++) begin
      exp_v = frame_exp(k, exp_q.pop_front());
      got_v = {ser_out, busy, tx_if.tx_ready, chip_idx};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL b2b_f0 cyc=%0d got=%b want=%b", k, got_v, exp_v);
      end
      step();
    end
    // The single idle-high cycle; tx_valid still high so the next frame
    // is taken at the end of it.
    got_v = {ser_out, busy, tx_if.tx_ready, chip_idx};
    checks++;
    if (got_v !== 5'b1_0_1_00) begin
      errors++;
      $display("FAIL b2b_gap got=%b want=10100", got_v);
    end
    step();
    tx_if.tx_valid = 1'b0;
    push_frame(8'hFF, 1'b0);
    for (int k = 1; k <= FRAME; k++) begin
      exp_v = frame_exp(k, exp_q.pop_front());
      got_v = {ser_out, busy, tx_if.tx_ready, chip_idx};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL b2b_f1 cyc=%0d got=%b want=%b", k, got_v, exp_v);
      end
      step();
    end
    step();
  endtask

  task automatic test_ignored();
    tx_if.tx_data = 8'h5A; tx_if.tx_valid = 1'b1;
    step();
    tx_if.tx_valid = 1'b0;
    push_frame(8'h5A, 1'b0);
    for (int k = 1; k <= FRAME; k++) begin
      if (k == 40) begin tx_if.tx_valid = 1'b1; tx_if.tx_data = 8'h3C; end
      if (k == 41) tx_if.tx_valid = 1'b0;
      exp_v = frame_exp(k, exp_q.pop_front());
      got_v = {ser_out, busy, tx_if.tx_ready, chip_idx};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL ignored cyc=%0d got=%b want=%b", k, got_v, exp_v);
      end
      step();
    end
    for (int k = 0; k < 3; k++) begin
      got_v = {ser_out, busy, tx_if.tx_ready, chip_idx};
      checks++;
      if (got_v !== 5'b1_0_1_00) begin
        errors++;
        $display("FAIL ignored_idle cyc=%0d got=%b want=10100", k, got_v);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    tx_if.tx_data = 8'hC3; tx_if.tx_valid = 1'b1;
    step();
    tx_if.tx_valid = 1'b0;
    push_frame(8'hC3, 1'b0);
    for (int k = 1; k < 50; k++) begin
      exp_v = frame_exp(k, exp_q.pop_front());
      got_v = {ser_out, busy, tx_if.tx_ready, chip_idx};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL rstmid_pre cyc=%0d got=%b want=%b", k, got_v, exp_v);
      end
      step();
    end
    exp_q.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
    got_v = {ser_out, busy, tx_if.tx_ready, chip_idx};
    checks++;
    if (got_v !== 5'b1_0_1_00) begin
      errors++;
      $display("FAIL rstmid_abort got=%b want=10100", got_v);
    end
    tx_if.tx_data = 8'h81; tx_if.tx_valid = 1'b1;
    step();
    tx_if.tx_valid = 1'b0;
    push_frame(8'h81, 1'b0);
    for (int k = 1; k <= FRAME; k++) begin
      exp_v = frame_exp(k, exp_q.pop_front());
      got_v = {ser_out, busy, tx_if.tx_ready, chip_idx};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL rstmid_new cyc=%0d got=%b want=%b", k, got_v, exp_v);
      end
      cap[k-1] = ser_out;
      step();
    end
    checks++;
    if (decode() !== 8'h81) begin
      errors++;
      $display("FAIL rstmid_decode got=%h want=81", decode());
    end
  endtask

  task automatic test_err_inj();
    logic       inj;
    logic [2:0] exp_chips, got_chips;
`ifdef RTL_ERR_INJECT_EN
    inj = 1'b1;
`else
    inj = 1'b0;
`endif
    exp_chips = inj ? 3'b101 : 3'b111;
    tx_if.tx_data = 8'h01; tx_if.tx_valid = 1'b1; err_inj = 1'b1;
    step();
    tx_if.tx_valid = 1'b0; err_inj = 1'b0;
    push_frame(8'h01, inj);
    for (int k = 1; k <= FRAME; k++) begin
      exp_v = frame_exp(k, exp_q.pop_front());
      got_v = {ser_out, busy, tx_if.tx_ready, chip_idx};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL errinj cyc=%0d got=%b want=%b", k, got_v, exp_v);
      end
      cap[k-1] = ser_out;
      step();
    end
    for (int c = 0; c < 3; c++) got_chips[2-c] = cap[3 * CD + c * CD + CD / 2];
    checks++;
    if (got_chips !== exp_chips) begin
      errors++;
      $display("FAIL errinj_chips got=%b want=%b", got_chips, exp_chips);
    end
    checks++;
    if (decode() !== 8'h01) begin
      errors++;
      $display("FAIL errinj_decode got=%h want=01", decode());
    end
    step();
  endtask

  initial begin
    rst = 1'b1; err_inj = 1'b0;
    tx_if.tx_valid = 1'b0; tx_if.tx_data = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_ignored();
    test_reset_mid();
    test_err_inj();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
